// File: rtl/parking_gate_arbiter.sv
// Round-robin sequencer sharing the occupancy block's single-event interface between gates.
// One gate is served at a time: vacancy check, barrier open, then a single ack and at most one commit pulse.
module parking_gate_arbiter #(
  parameter int unsigned NUM_GATES   = 4,
  parameter int unsigned GW          = 2,
  parameter int unsigned OPEN_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_GATES-1:0] gate_req,
  input  logic [NUM_GATES-1:0] gate_is_exit,
  input  logic [NUM_GATES-1:0] gate_is_uni,
  input  logic [NUM_GATES-1:0] gate_passed,
  input  logic                 uni_is_vacated_space,
  input  logic                 is_vacated_space,
  output logic [NUM_GATES-1:0] gate_ack,
  output logic                 gate_refused,
  output logic [NUM_GATES-1:0] barrier_open,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic [GW-1:0]        grant_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, CHECK, OPEN, DONE} state_t;

  localparam logic [7:0] OPEN_LIM = 8'(OPEN_CYCLES);

  state_t                 state;
  logic [GW-1:0]          ptr;
  logic                   is_exit;
  logic                   is_uni;
  logic [7:0]             open_cnt;

  logic [GW-1:0]          idx;
  logic [GW-1:0]          pick;
  logic                   pick_valid;
  logic [NUM_GATES-1:0]   grant_hot;
  logic                   proceed;
  logic                   finish;
  logic                   finish_refused;

  // First requesting gate at or above the pointer, wrapping around.
  always_comb begin
    idx        = '0;
    pick       = '0;
    pick_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_GATES; i++) begin
      idx = GW'((32'(ptr) + i) % NUM_GATES);
      if (!pick_valid && gate_req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    grant_hot      = NUM_GATES'(1) << grant_id;
    proceed        = is_exit || (is_uni ? uni_is_vacated_space : is_vacated_space);
    finish         = 1'b0;
    finish_refused = 1'b0;
    case (state)
      CHECK: begin
        finish         = !proceed;
        finish_refused = 1'b1;
      end
      OPEN: begin
        // A car clearing the loop wins over a same-cycle timeout or abort.
        if (gate_passed[grant_id]) begin
          finish         = 1'b1;
          finish_refused = 1'b0;
        end else if (open_cnt == OPEN_LIM || !gate_req[grant_id]) begin
          finish         = 1'b1;
          finish_refused = 1'b1;
        end
      end
      default: begin
        finish         = 1'b0;
        finish_refused = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      ptr                <= '0;
      is_exit            <= 1'b0;
      is_uni             <= 1'b0;
      open_cnt           <= '0;
      gate_ack           <= '0;
      gate_refused       <= 1'b0;
      barrier_open       <= '0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      grant_id           <= '0;
      busy               <= 1'b0;
    end else begin
      gate_ack           <= '0;
      gate_refused       <= 1'b0;
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;

      if (finish) begin
        state        <= DONE;
        barrier_open <= '0;
        gate_ack     <= grant_hot;
        gate_refused <= finish_refused;
        if (!finish_refused) begin
          if (is_exit) begin
            car_exited        <= 1'b1;
            is_uni_car_exited <= is_uni;
          end else begin
            car_entered        <= 1'b1;
            is_uni_car_entered <= is_uni;
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (pick_valid) begin
              grant_id <= pick;
              is_exit  <= gate_is_exit[pick];
              is_uni   <= gate_is_uni[pick];
              ptr      <= GW'((32'(pick) + 1) % NUM_GATES);
              busy     <= 1'b1;
              state    <= CHECK;
            end
          end
          CHECK: begin
            barrier_open <= grant_hot;
            open_cnt     <= 8'd1;
            state        <= OPEN;
          end
          OPEN: begin
            open_cnt <= open_cnt + 8'd1;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Self-checking bench for parking_gate_arbiter: directed transaction table, randomized
// transactions against a service-level model, reset and round-robin sequences.
module tb_parking_gate_arbiter;

  localparam int unsigned NG = 4;
  localparam int unsigned GWID = 2;
  localparam int unsigned OC = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NG-1:0] gate_req = '0;
  logic [NG-1:0] gate_is_exit = '0;
  logic [NG-1:0] gate_is_uni = '0;
  logic [NG-1:0] gate_passed = '0;
  logic          uni_is_vacated_space = 1'b0;
  logic          is_vacated_space = 1'b0;
  logic [NG-1:0] gate_ack;
  logic          gate_refused;
  logic [NG-1:0] barrier_open;
  logic          car_entered;
  logic          is_uni_car_entered;
  logic          car_exited;
  logic          is_uni_car_exited;
  logic [GWID-1:0] grant_id;
  logic          busy;

  parking_gate_arbiter #(
    .NUM_GATES  (NG),
    .GW         (GWID),
    .OPEN_CYCLES(OC)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .gate_req            (gate_req),
    .gate_is_exit        (gate_is_exit),
    .gate_is_uni         (gate_is_uni),
    .gate_passed         (gate_passed),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .gate_ack            (gate_ack),
    .gate_refused        (gate_refused),
    .barrier_open        (barrier_open),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .grant_id            (grant_id),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ex;
    logic [3:0] uni;
    logic       vac;
    logic       uvac;
    int         pass_k;   // OPEN cycle on which the granted gate's loop fires, 0 = never
    int         abort_k;  // OPEN cycle from which the request is dropped, 0 = never
    int         exp_g;
    logic       exp_ref;
    int         exp_open; // cycles the barrier is open, 0 = refused at the vacancy check
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;
  int model_ptr = 0;

  function automatic logic [15:0] mk(input logic [3:0] ack, input logic rf, input logic [3:0] bar,
                                     input logic ce, input logic uce, input logic cx, input logic ucx,
                                     input logic bsy, input logic [1:0] gid);
    return {ack, rf, bar, ce, uce, cx, ucx, bsy, gid};
  endfunction

  function automatic logic [15:0] act();
    return mk(gate_ack, gate_refused, barrier_open, car_entered, is_uni_car_entered,
              car_exited, is_uni_car_exited, busy, grant_id);
  endfunction

  task automatic cmp(input string name, input int c, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
    end
  endtask

  task automatic run_txn(input string name, input vec_t v);
    int d;
    logic [15:0] e;
    logic [3:0] hot;
    logic exg, ung, fin, cm;
    hot = 4'(1) << v.exp_g;
    exg = v.ex[v.exp_g];
    ung = v.uni[v.exp_g];
    d = (v.exp_open == 0) ? 2 : v.exp_open + 2;
    gate_req = v.req;
    gate_is_exit = v.ex;
    gate_is_uni = v.uni;
    is_vacated_space = v.vac;
    uni_is_vacated_space = v.uvac;
    gate_passed = '0;
    for (int c = 1; c <= d; c++) begin
      @(posedge clk); #1;
      fin = (c == d);
      cm = fin && !v.exp_ref;
      e = mk(fin ? hot : 4'b0, fin && v.exp_ref,
             (v.exp_open > 0 && c >= 2 && c <= v.exp_open + 1) ? hot : 4'b0,
             cm && !exg, cm && !exg && ung, cm && exg, cm && exg && ung,
             1'b1, 2'(v.exp_g));
      cmp(name, c, act(), e);
      if (fin) begin
        gate_req = '0;
        gate_passed = '0;
      end else begin
        gate_passed = 4'($urandom) & ~hot;
        if (v.pass_k != 0 && c == v.pass_k + 1) gate_passed = gate_passed | hot;
        if (v.abort_k != 0 && c >= v.abort_k + 1) gate_req = gate_req & ~hot;
      end
    end
    @(posedge clk); #1;
    cmp({name, "_idle"}, d + 1, act() & ~16'h0003, 16'h0000);
    model_ptr = (v.exp_g + 1) % NG;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    vec_t rv;
    int order[$];
    int exp_ord[5];
    logic [3:0] prev_ack;
    logic found;
    logic prc;
    int endc;

    tbl[0] = '{4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b1,  3, 0, 1, 1'b0,  3};
    tbl[1] = '{4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0,  0, 0, 2, 1'b1,  0};
    tbl[2] = '{4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0,  0, 0, 3, 1'b1, 10};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1,  0, 4, 0, 1'b1,  4};
    tbl[4] = '{4'b0010, 4'b0010, 4'b0010, 1'b0, 1'b0, 10, 0, 1, 1'b0, 10};
    tbl[5] = '{4'b1111, 4'b0100, 4'b0100, 1'b1, 1'b1,  1, 0, 2, 1'b0,  1};
    tbl[6] = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 1'b1,  2, 0, 0, 1'b0,  2};
    tbl[7] = '{4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1,  0, 0, 0, 1'b1,  0};
    tbl[8] = '{4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b0,  2, 2, 2, 1'b0,  2};
    exp_ord = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", 0, act(), 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_txn($sformatf("table%0d", i), tbl[i]);

    // Randomized services against the model.
    for (int t = 0; t < 150; t++) begin
      rv.req = 4'($urandom_range(1, 15));
      rv.ex = 4'($urandom);
      rv.uni = 4'($urandom);
      rv.vac = ($urandom_range(0, 3) != 0);
      rv.uvac = ($urandom_range(0, 3) != 0);
      rv.pass_k = $urandom_range(0, 12);
      rv.abort_k = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 12) : 0;
      found = 1'b0;
      rv.exp_g = 0;
      for (int i = 0; i < NG; i++) begin
        if (!found && rv.req[(model_ptr + i) % NG]) begin
          rv.exp_g = (model_ptr + i) % NG;
          found = 1'b1;
        end
      end
      prc = rv.ex[rv.exp_g] || (rv.uni[rv.exp_g] ? rv.uvac : rv.vac);
      if (!prc) begin
        rv.exp_open = 0;
        rv.exp_ref = 1'b1;
      end else begin
        endc = OC;
        if (rv.abort_k != 0 && rv.abort_k < endc) endc = rv.abort_k;
        if (rv.pass_k != 0 && rv.pass_k <= endc) begin
          endc = rv.pass_k;
          rv.exp_ref = 1'b0;
        end else begin
          rv.exp_ref = 1'b1;
        end
        rv.exp_open = endc;
      end
      run_txn("rand", rv);
    end

    // Reset while gate 2's barrier is open.
    gate_req = 4'b0100;
    gate_is_exit = '0;
    gate_is_uni = '0;
    is_vacated_space = 1'b1;
    gate_passed = '0;
    for (int c = 0; c < 6 && barrier_open != 4'b0100; c++) begin
      @(posedge clk); #1;
    end
    cmp("rst_setup_barrier", 0, {12'b0, barrier_open}, 16'h0004);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("rst_async_outputs", 0, act(), 16'h0000);
    @(posedge clk); #1;
    gate_req = '0;
    rst_n = 1'b1;
    model_ptr = 0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      cmp("rst_quiet", c, act(), 16'h0000);
    end
    rv = '{4'b0101, 4'b0000, 4'b0000, 1'b1, 1'b1, 1, 0, 0, 1'b0, 1};
    run_txn("rst_first_grant", rv);

    // All gates requesting continuously from reset.
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    gate_req = 4'b1111;
    gate_is_exit = 4'b1111;
    gate_is_uni = '0;
    gate_passed = 4'b1111;
    prev_ack = '0;
    for (int cyc = 0; cyc < 60 && order.size() < 5; cyc++) begin
      @(posedge clk); #1;
      gate_req = 4'b1111;
      cmp("rr_barrier_onehot", cyc, {15'b0, $onehot0(barrier_open)}, 16'h0001);
      if (gate_ack != 4'b0) begin
        cmp("rr_ack_single", cyc, {12'b0, prev_ack}, 16'h0000);
        cmp("rr_ack_onehot", cyc, {15'b0, $onehot(gate_ack)}, 16'h0001);
        for (int i = 0; i < NG; i++) if (gate_ack[i]) order.push_back(i);
        gate_req = ~gate_ack;
      end
      prev_ack = gate_ack;
    end
    cmp("rr_ack_count", 0, 16'(order.size()), 16'd5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      cmp("rr_order", i, 16'(order[i]), 16'(exp_ord[i]));
    gate_req = '0;
    gate_passed = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Sequencer that shares the single-event interface of the parking occupancy block between several physical gates. It round-robins gate requests, checks the occupancy block's vacancy flags for entries, drives the granted gate's barrier, and commits exactly one `car_entered`/`car_exited` pulse per car that physically clears the barrier. The occupancy block therefore never sees simultaneous events, and capacity is never exceeded by racing gates.

## Interface
- `NUM_GATES`, 4: number of gates, 2..8.
- `GW`, 2: grant index width; set to ceil(log2(NUM_GATES)).
- `OPEN_CYCLES`, 10: maximum cycles a barrier stays open waiting for the car, 1..255.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `gate_req` in NUM_GATES: gate g wants a car through; held until `gate_ack[g]`.
- `gate_is_exit` in NUM_GATES: 1 = exit, 0 = entry; stable while `gate_req[g]` is high.
- `gate_is_uni` in NUM_GATES: 1 = university car; stable while `gate_req[g]` is high.
- `gate_passed` in NUM_GATES: loop sensor, car cleared barrier g (level or pulse).
- `uni_is_vacated_space` in 1: university space free (from the occupancy block).
- `is_vacated_space` in 1: public space free (from the occupancy block).
- `gate_ack` out NUM_GATES: one-cycle pulse; the request is finished.
- `gate_refused` out 1: qualifies `gate_ack`: 1 = no car counted.
- `barrier_open` out NUM_GATES: level; at most one bit set.
- `car_entered`, `is_uni_car_entered`, `car_exited`, `is_uni_car_exited` out 1 each: one-cycle commit pulses to the occupancy block.
- `grant_id` out GW: gate currently served; valid while `busy`.
- `busy` out 1: state is not IDLE.

## Operation
- All outputs are registered. Reset value of every output is 0. The state resets to IDLE. The round-robin pointer resets to 0.
- **IDLE:** if any `gate_req` bit is set, select the first set bit searching upward from the pointer, with wrap-around. Latch its index, `gate_is_exit` and `gate_is_uni`. Set pointer = index+1 mod NUM_GATES. Go to CHECK.
- **CHECK** (one cycle):
  - An exit always proceeds.
  - An entry proceeds only if its class flag is 1: `uni_is_vacated_space` for uni cars, `is_vacated_space` for public cars.
  - Proceed → OPEN. Otherwise → DONE with refused=1.
- **OPEN:**
  - `barrier_open[grant_id]`=1. An 8-bit counter counts cycles spent in OPEN.
  - `gate_passed[grant_id]` sampled high → DONE, refused=0.
  - Else, counter reaches OPEN_CYCLES or `gate_req[grant_id]` drops (abort) → DONE, refused=1.
  - Passed and timeout/abort in the same cycle: passed wins.
  - `gate_passed` bits of other gates are ignored.
- **DONE** (one cycle):
  - `barrier_open`=0 and `gate_ack[grant_id]`=1.
  - `gate_refused` = the latched refused value.
  - If refused=0: exactly one commit pulse.
    - Entry: `car_entered`=1, `is_uni_car_entered`=latched uni.
    - Exit: `car_exited`=1, `is_uni_car_exited`=latched uni.
  - Next state is IDLE.
- The requester drops `gate_req` during its ack cycle. The IDLE cycle after DONE guarantees a dropped request is not re-granted. It also gives the occupancy block's flags time to update before the next CHECK.
- Exits are never refused for vacancy. The occupancy block ignores exits at zero count.
- A gate is never granted twice in a row while another gate requests. Starvation bound: NUM_GATES−1 services.
- Reset asserted mid-operation: the barrier closes immediately, no commit pulse and no ack are produced, and the state returns to IDLE.

## Timing
- Request visible at edge 0 in IDLE → CHECK at cycle 1 → `barrier_open` high at cycle 2.
- Refused entry: `gate_ack` and `gate_refused` high at cycle 2.
- `gate_passed` sampled at OPEN cycle k → DONE (ack + commit) at cycle k+1, with the barrier already low.
- Timeout: the barrier is open exactly OPEN_CYCLES cycles, then DONE with refused=1.
- Minimum service period is 4 cycles (IDLE, CHECK, OPEN, DONE) for a pass on the first OPEN cycle. A refused entry takes 3 cycles.
- Commit pulses are never back-to-back: at least 3 cycles separate successive commits.

## Test plan
- Single public entry at gate 1, `is_vacated_space`=1, `gate_passed[1]` on the 3rd OPEN cycle → `barrier_open`=4'b0010 for 3 cycles, then `gate_ack`=4'b0010, `car_entered`=1, `is_uni_car_entered`=0, `gate_refused`=0.
- Uni entry with `uni_is_vacated_space`=0 → no barrier; `gate_ack` and `gate_refused` high 2 cycles after the request; all commit pulses 0.
- All 4 gates request continuously after reset → grant order 0,1,2,3,0. Each ack is a single cycle, and `barrier_open` is never more than one-hot.
- Exit at gate 3, no `gate_passed`, OPEN_CYCLES=10 → barrier high exactly 10 cycles, then ack with refused=1 and `car_exited`=0.
- Abort and simultaneous events:
  - Request dropped during OPEN → refused ack on the next cycle.
  - `gate_passed` on the same cycle as timeout → refused=0 and a commit pulse.
- `rst_n` pulsed low while `barrier_open[2]`=1 → all outputs 0 asynchronously. After release, no ack or commit until a new request; the first grant goes to gate 0 when gates 0 and 2 both request.
